// File: rtl/ram_2x113_queue_ctrl_pkg.sv
// ram_2x113_queue_ctrl_pkg
// Shared constants and types for the two-entry, 113-bit queue controller
// and its backing RAM.
//   WIDTH   : payload width in bits (113)
//   DEPTH   : number of queue entries (2)
//   ptr_t   : one-bit RAM address / queue pointer
//   count_t : two-bit occupancy, 0..2
package ram_2x113_queue_ctrl_pkg;

  localparam int WIDTH = 113;
  localparam int DEPTH = 2;

  typedef logic [0:0] ptr_t;
  typedef logic [1:0] count_t;

  localparam count_t COUNT_EMPTY = 2'd0;
  localparam count_t COUNT_ONE   = 2'd1;
  localparam count_t COUNT_FULL  = 2'd2;

  // Occupancy as a function of the pointer pair and the wrap flag.
  // Equal pointers are ambiguous, and maybe_full resolves them.
  function automatic count_t calc_count(input ptr_t enq_ptr,
                                        input ptr_t deq_ptr,
                                        input logic maybe_full);
    count_t c;
    c = COUNT_ONE;
    if (enq_ptr == deq_ptr) begin
      c = maybe_full ? COUNT_FULL : COUNT_EMPTY;
    end
    return c;
  endfunction

endpackage

// File: rtl/ram_2x113.sv
// ram_2x113
// Two-entry, 113-bit storage array with one write port and one
// combinational read port. The array has no reset; the queue controller
// tracks validity through its own pointer state.
// Ports:
//   R0_addr  in  : read address
//   R0_en    in  : read enable (data reads as zero when low)
//   R0_clk   in  : read clock (read is combinational, clock unused)
//   R0_data  out : read data, zero latency
//   W0_addr  in  : write address
//   W0_en    in  : write enable
//   W0_clk   in  : write clock, writes on posedge
//   W0_data  in  : write data
module ram_2x113
  import ram_2x113_queue_ctrl_pkg::*;
(
  input  ptr_t               R0_addr,
  input  logic               R0_en,
  input  logic               R0_clk,
  output logic [WIDTH-1:0]   R0_data,
  input  ptr_t               W0_addr,
  input  logic               W0_en,
  input  logic               W0_clk,
  input  logic [WIDTH-1:0]   W0_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // The read path is asynchronous, so the read clock has no load.
  logic w_r0_clk_unused;
  assign w_r0_clk_unused = R0_clk;

  always_ff @(posedge W0_clk) begin
    if (W0_en) begin
      r_mem[W0_addr] <= W0_data;
    end
  end

  assign R0_data = R0_en ? r_mem[R0_addr] : '0;

endmodule

// File: rtl/ram_2x113_queue_ctrl.sv
// ram_2x113_queue_ctrl
// Two-entry FIFO controller in front of a ram_2x113 array. No flow-through
// and no pipe mode: an entry written in cycle N is first offered in N+1, and
// a full queue never accepts even while it is being drained.
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; ready/valid are combinational from registered state and
// io_flush only, and never depend on the partner's valid/ready.
// Ports:
//   clock         in  : single clock, all state on posedge
//   reset         in  : asynchronous active-high reset
//   io_enq_valid  in  : producer offers io_enq_bits
//   io_enq_ready  out : controller accepts an entry this cycle
//   io_enq_bits   in  : payload to store
//   io_deq_valid  out : io_deq_bits holds the oldest entry
//   io_deq_ready  in  : consumer takes the entry this cycle
//   io_deq_bits   out : oldest stored payload
//   io_flush      in  : synchronous discard of all entries
//   io_count      out : current occupancy 0..2
module ram_2x113_queue_ctrl
  import ram_2x113_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = ram_2x113_queue_ctrl_pkg::DEPTH,
  parameter int WIDTH = ram_2x113_queue_ctrl_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  input  logic             io_flush,
  output count_t           io_count
);

  // The RAM macro is fixed in size; any other geometry is a build error.
  if (DEPTH != ram_2x113_queue_ctrl_pkg::DEPTH) begin : g_bad_depth
    $error("ram_2x113_queue_ctrl: DEPTH must be 2 to match ram_2x113");
  end
  if (WIDTH != ram_2x113_queue_ctrl_pkg::WIDTH) begin : g_bad_width
    $error("ram_2x113_queue_ctrl: WIDTH must be 113 to match ram_2x113");
  end

  ptr_t r_enq_ptr;
  ptr_t r_deq_ptr;
  logic r_maybe_full;

  logic w_ptr_match;
  logic w_empty;
  logic w_full;
  logic w_do_enq;
  logic w_do_deq;

  assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match &  r_maybe_full;

  // Flush masks both sides, so nothing fires in the flush cycle.
  assign io_enq_ready = ~w_full  & ~io_flush;
  assign io_deq_valid = ~w_empty & ~io_flush;

  assign w_do_enq = io_enq_valid & io_enq_ready;
  assign w_do_deq = io_deq_valid & io_deq_ready;

  assign io_count = calc_count(r_enq_ptr, r_deq_ptr, r_maybe_full);

  // Pointers are one bit wide, so +1 wraps 1->0 by itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else if (io_flush) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_do_enq) begin
        r_enq_ptr <= r_enq_ptr + 1'b1;
      end
      if (w_do_deq) begin
        r_deq_ptr <= r_deq_ptr + 1'b1;
      end
      // Simultaneous enq and deq leaves occupancy, and the flag, unchanged.
      if (w_do_enq != w_do_deq) begin
        r_maybe_full <= w_do_enq;
      end
    end
  end

  ram_2x113 u_ram (
    .R0_addr (r_deq_ptr),
    .R0_en   (1'b1),
    .R0_clk  (clock),
    .R0_data (io_deq_bits),
    .W0_addr (r_enq_ptr),
    .W0_en   (w_do_enq),
    .W0_clk  (clock),
    .W0_data (io_enq_bits)
  );

endmodule

// File: tb/tb_ram_2x113_queue_ctrl.sv
module tb_ram_2x113_queue_ctrl;
  import ram_2x113_queue_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic         io_enq_valid;
  logic         io_enq_ready;
  logic [112:0] io_enq_bits;
  logic         io_deq_valid;
  logic         io_deq_ready;
  logic [112:0] io_deq_bits;
  logic         io_flush;
  count_t       io_count;

  always #5 clock = ~clock;

  ram_2x113_queue_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .io_enq_valid (io_enq_valid),
    .io_enq_ready (io_enq_ready),
    .io_enq_bits  (io_enq_bits),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_flush     (io_flush),
    .io_count     (io_count)
  );

  // ---------------- scoreboard ----------------
  logic [112:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [112:0] obs,
                       input logic [112:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [112:0] rnd113();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[112:0];
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge: drives inputs, checks the combinational
  // outputs against the queue model, updates the model for the coming
  // posedge, then waits for the next negedge.
  task automatic cycle(input logic ev, input logic [112:0] eb,
                       input logic dr, input logic fl);
    int occ;
    logic exp_er;
    logic exp_dv;
    logic [112:0] d;
    io_enq_valid = ev;
    io_enq_bits  = eb;
    io_deq_ready = dr;
    io_flush     = fl;
    #1;
    occ    = exp_q.size();
    exp_er = (occ < 2) && !fl;
    exp_dv = (occ > 0) && !fl;
    check("count",     113'(io_count),     113'(occ));
    check("enq_ready", 113'(io_enq_ready), 113'(exp_er));
    check("deq_valid", 113'(io_deq_valid), 113'(exp_dv));
    if (exp_dv && dr) begin
      d = exp_q.pop_front();
      check("deq_bits", io_deq_bits, d);
    end
    if (exp_er && ev) exp_q.push_back(eb);
    if (fl) exp_q.delete();
    @(negedge clock);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b1;
    io_enq_valid = 1'b0;
    io_enq_bits  = '0;
    io_deq_ready = 1'b0;
    io_flush     = 1'b0;

    // Outputs while reset is held.
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    reset = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Back-to-back fill, then a refused third enq.
    cycle(1'b1, 113'h1_AAAA, 1'b0, 1'b0);
    cycle(1'b1, 113'h1_BBBB, 1'b0, 1'b0);
    cycle(1'b1, 113'h1_CCCC, 1'b0, 1'b0);

    // Full with both sides asking: only the deq fires.
    cycle(1'b1, 113'h1_CCCC, 1'b1, 1'b0);
    cycle(1'b1, 113'h1_CCCC, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Count stays at one across eight simultaneous enq/deq cycles.
    cycle(1'b1, rnd113(), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, rnd113(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // No flow-through into an empty queue.
    cycle(1'b1, 113'h0_0F0F, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Data on a non-valid enq is never stored.
    cycle(1'b0, 113'h1_DEAD, 1'b0, 1'b0);
    cycle(1'b1, 113'h0_1234, 1'b0, 1'b0);
    cycle(1'b0, 113'h1_BEEF, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Flush while full with both sides active.
    cycle(1'b1, 113'h0_5555, 1'b0, 1'b0);
    cycle(1'b1, 113'h0_6666, 1'b0, 1'b0);
    cycle(1'b1, 113'h0_7777, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 113'h0_8888, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges with the queue full.
    cycle(1'b1, 113'h1_1111, 1'b0, 1'b0);
    cycle(1'b1, 113'h1_2222, 1'b0, 1'b0);
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_count",     113'(io_count),     113'(0));
    check("async_rst_deq_valid", 113'(io_deq_valid), 113'(0));
    check("async_rst_enq_ready", 113'(io_enq_ready), 113'(1));
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 113'h1_3333, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), rnd113(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
    end
    while (exp_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_2x113_queue_ctrl.md
RAM_2X113_QUEUE_CTRL -- requirements
Module: ram_2x113_queue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entries; fixed to match ram_2x113, elaboration error otherwise.
REQ-002 SHALL have parameter WIDTH, default 113, payload bits; fixed to match ram_2x113, elaboration error otherwise.
REQ-003 clock  input  1  single clock; all state on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_enq_valid  input  1  producer offers io_enq_bits.
REQ-006 io_enq_ready  output  1  controller accepts an entry this cycle.
REQ-007 io_enq_bits  input  113  payload to store.
REQ-008 io_deq_valid  output  1  io_deq_bits holds the oldest entry.
REQ-009 io_deq_ready  input  1  consumer takes the entry this cycle.
REQ-010 io_deq_bits  output  113  oldest stored payload.
REQ-011 io_flush  input  1  synchronous discard of all entries.
REQ-012 io_count  output  2  current occupancy, 0..2.

Function
REQ-013 enq fire = io_enq_valid & io_enq_ready; deq fire = io_deq_valid & io_deq_ready.
REQ-014 State: enq_ptr (1b), deq_ptr (1b), maybe_full (1b); empty = ptrs equal & !maybe_full; full = ptrs equal & maybe_full.
REQ-015 io_enq_ready = !full & !io_flush; io_deq_valid = !empty & !io_flush (combinational).
REQ-016 On enq fire: RAM write W0_en=1, W0_addr=enq_ptr, W0_data=io_enq_bits; enq_ptr increments, wrapping 1->0.
REQ-017 On deq fire: deq_ptr increments, wrapping 1->0; no RAM write.
REQ-018 RAM read port driven R0_en=1, R0_addr=deq_ptr; io_deq_bits = R0_data (combinational read, zero latency).
REQ-019 io_deq_bits value unspecified when io_deq_valid=0; no requirement on it.
REQ-020 maybe_full next = 1 when enq fire & !deq fire; 0 when deq fire & !enq fire; unchanged otherwise.
REQ-021 Simultaneous enq and deq fire (count=1 only, since full blocks enq and empty blocks deq): both pointers advance, count unchanged.
REQ-022 No flow-through: entry written in cycle N first visible on io_deq_valid in cycle N+1.
REQ-023 No pipe mode: when full, io_enq_ready=0 even if io_deq_ready=1.
REQ-024 io_flush=1: next cycle enq_ptr=0, deq_ptr=0, maybe_full=0; no enq/deq fires during the flush cycle; RAM contents untouched.
REQ-025 io_count = 2 when full, 0 when empty, 1 otherwise; registered state only, so updates the cycle after a fire.
REQ-026 Enq data with io_enq_valid=0 SHALL never be written.

Reset
REQ-027 reset asserted: enq_ptr=0, deq_ptr=0, maybe_full=0 immediately, independent of clock.
REQ-028 During and after reset: io_enq_ready=1 (unless io_flush), io_deq_valid=0, io_count=0.
REQ-029 RAM storage SHALL NOT be reset; emptiness is guaranteed by pointer state alone.
REQ-030 Reset asserted mid-transfer SHALL abort it; no partial state survives deassertion.

Structure
REQ-031 Shared package holds WIDTH=113, DEPTH=2, and the ptr_t (1-bit) and count_t (2-bit) typedefs.
REQ-032 Exactly one sub-module: an instance of ram_2x113, R0_clk and W0_clk tied to clock.
REQ-033 Pointer/maybe_full logic in one registered process with async reset; all handshake outputs combinational from state and io_flush.

Verification
REQ-034 Reset, then enq 0x1_AAAA, 0x1_BBBB back-to-back, io_deq_ready=0 -> io_count 1 then 2, io_enq_ready=0 after second; deq yields 0x1_AAAA then 0x1_BBBB.
REQ-035 Full, io_enq_valid=1, io_deq_ready=1 -> one deq fire only, io_count 2->1, next cycle enq accepted, count back to 2.
REQ-036 Count=1, enq and deq fire same cycle, 8 cycles continuous -> io_count stays 1, pointers wrap 1->0 repeatedly, data order preserved.
REQ-037 Enq 0x0_0F0F into empty -> io_deq_valid=0 same cycle, 1 next cycle with io_deq_bits=0x0_0F0F.
REQ-038 Full, pulse io_flush with io_enq_valid=1 -> io_enq_ready=0 and io_deq_valid=0 during pulse; next cycle io_count=0, io_deq_valid=0, no write occurred.
REQ-039 Assert reset asynchronously with io_count=2, between clock edges -> io_count=0, io_deq_valid=0 before next posedge.
